fetch_queue: RTL

Parametrised instruction fetch stage with a prefetch queue. It generates the fetch PC, issues one request per cycle to a synchronous instruction memory with fixed one-cycle latency, and buffers the returned words with their PCs in a DEPTH-entry FIFO. Decode consumes entries through a valid/ready handshake. The block sits between the PC-redirect logic (branch/jump/exception) and decode, and replaces the free-running PC register with redirect support and back-pressure.

---
 rtl/fetch_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a prefetch queue.
// Generates the fetch PC, issues one request per cycle to a synchronous
// one-cycle-latency instruction memory, and buffers returned words together
// with their PCs in a DEPTH-entry FIFO that decode drains via valid/ready.
// A redirect flushes the stage and requests the new target in the same cycle.
module fetch_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP    = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_redirect,
    input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
    output logic                         o_imem_req,
    output logic [ADDR_WIDTH-1:0]        o_imem_addr,
    input  logic [DATA_WIDTH-1:0]        i_imem_rdata,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [DATA_WIDTH-1:0]        o_out_inst,
    output logic [ADDR_WIDTH-1:0]        o_out_pc,
    output logic [$clog2(DEPTH):0]       o_count
);

    // Index width addresses the storage; pointers carry one extra wrap bit
    // so that full (same index, different wrap) and empty are distinguishable.
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned PTRW = IDXW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
    localparam logic [PTRW:0]         DEPTH_WIDE = (PTRW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflightPc;
    logic [PTRW-1:0]       r_head;
    logic [PTRW-1:0]       r_tail;

    logic [DATA_WIDTH-1:0] r_instMem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pcMem   [DEPTH];

    logic                  w_redirect;
    logic [PTRW-1:0]       w_count;
    logic [PTRW:0]         w_creditUsed;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [IDXW-1:0]       w_headIdx;
    logic [IDXW-1:0]       w_tailIdx;

    // Request, credit and handshake decode. A redirect is ignored while in
    // reset so the reset-state outputs stay quiet regardless of other inputs.
    always_comb begin
        w_redirect   = i_redirect && !i_rst;
        w_count      = r_tail - r_head;
        w_creditUsed = {1'b0, w_count} + {{PTRW{1'b0}}, r_inflight};
        w_issue      = !i_rst && !i_stall && (w_creditUsed < DEPTH_WIDE);
        w_headIdx    = r_head[IDXW-1:0];
        w_tailIdx    = r_tail[IDXW-1:0];

        o_imem_req   = w_issue || w_redirect;
        o_imem_addr  = w_redirect ? i_redirect_pc : r_pc;

        o_out_valid  = (w_count != '0) && !w_redirect;
        o_out_inst   = r_instMem[w_headIdx];
        o_out_pc     = r_pcMem[w_headIdx];
        o_count      = w_count;

        // A response arriving in a redirect cycle belongs to the old path.
        w_push       = r_inflight && !w_redirect && !i_rst;
        w_pop        = o_out_valid && i_out_ready;
    end

    // Fetch PC, in-flight tracking and queue pointers. Redirect wins over
    // stall, push and pop; the credit rule guarantees a push never overflows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_PC;
            r_inflight   <= 1'b0;
            r_inflightPc <= RESET_PC;
            r_head       <= '0;
            r_tail       <= '0;
        end else if (w_redirect) begin
            r_pc         <= i_redirect_pc + STEP;
            r_inflight   <= 1'b1;
            r_inflightPc <= i_redirect_pc;
            r_head       <= r_tail;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc         <= r_pc + STEP;
                r_inflightPc <= r_pc;
            end
            if (w_push) begin
                r_tail <= r_tail + PTRW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTRW'(1);
            end
        end
    end

    // Entry storage. Cleared on reset so the head outputs read zero until the
    // first word lands; afterwards an empty queue just shows stale contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_instMem[i] <= '0;
                r_pcMem[i]   <= '0;
            end
        end else if (w_push) begin
            r_instMem[w_tailIdx] <= i_imem_rdata;
            r_pcMem[w_tailIdx]   <= r_inflightPc;
        end
    end

endmodule
